// File: rtl/imem_dump_streamer.sv
`default_nettype none
// ============================================================================
// Module   : imem_dump_streamer
// Brief    : Streams a whole-word byte range out of a synchronous byte-read
//            memory port onto a valid/ready byte stream.
// Revision : 1.0 - initial release
// ============================================================================
module imem_dump_streamer #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  mem_read_enable,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_read_data,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    output logic [1:0]            out_index,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_SEND   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    localparam logic [LEN_WIDTH-1:0] c_WORD_MASK = {{(LEN_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [LEN_WIDTH-1:0] c_LEN_ONE   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0] c_LEN_ZERO  = '0;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic [1:0]            r_index;
    logic [7:0]            r_data;
    logic [LEN_WIDTH-1:0]  w_eff_len;
    logic                  w_handshake;

    assign w_eff_len   = length & c_WORD_MASK;
    assign w_handshake = (r_state == S_SEND) && out_ready;

    // r_index tracks (address - base) mod 4 without a full-width subtract
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_index     <= 2'd0;
            r_data      <= 8'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && start) begin
                r_addr      <= base_addr;
                r_remaining <= w_eff_len;
                r_index     <= 2'd0;
            end
            if (r_state == S_WAIT) begin
                r_data <= mem_read_data;
            end
            if (w_handshake) begin
                r_addr      <= r_addr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
                r_index     <= r_index + 2'd1;
            end
        end
    end

    always_comb begin
        w_next_state    = r_state;
        mem_read_enable = 1'b0;
        out_valid       = 1'b0;
        out_index       = 2'd0;
        out_last        = 1'b0;
        busy            = 1'b1;
        done            = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next_state = (w_eff_len == c_LEN_ZERO) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_read_enable = 1'b1;
                w_next_state    = S_WAIT;
            end
            S_WAIT: begin
                w_next_state = S_SEND;
            end
            S_SEND: begin
                out_valid = 1'b1;
                out_index = r_index;
                out_last  = (r_remaining == c_LEN_ONE);
                // remaining is at least 1 here, so "not one" means more bytes follow
                if (out_ready) begin
                    w_next_state = (r_remaining != c_LEN_ONE) ? S_ISSUE : S_FINISH;
                end
            end
            S_FINISH: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign mem_addr = r_addr;
    assign out_data = r_data;

endmodule
`default_nettype wire

// File: tb/tb_imem_dump_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_dump_streamer
// Brief    : Scoreboard bench for imem_dump_streamer with a byte memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_dump_streamer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] length;
    logic        mem_read_enable;
    logic [31:0] mem_addr;
    logic [7:0]  mem_read_data;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_index;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic        done;

    imem_dump_streamer #(.ADDR_WIDTH(32), .LEN_WIDTH(16)) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .base_addr       (base_addr),
        .length          (length),
        .mem_read_enable (mem_read_enable),
        .mem_addr        (mem_addr),
        .mem_read_data   (mem_read_data),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_index       (out_index),
        .out_last        (out_last),
        .out_ready       (out_ready),
        .busy            (busy),
        .done            (done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] idx;
        logic       last;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rd_q[$];
    logic [7:0]  mem [logic [31:0]];
    int          checks   = 0;
    int          failures = 0;
    int          reads_cnt = 0;
    int          hs_cnt    = 0;
    int          cur_len   = 0;
    logic        prev_last_hs = 1'b0;
    logic        stall_prev   = 1'b0;
    logic [7:0]  s_data;
    logic [1:0]  s_idx;
    logic        s_last;

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        logic [7:0] v;
        if (mem.exists(a)) v = mem[a];
        else               v = a[7:0] ^ 8'h5A;
        return v;
    endfunction

    // one-cycle read latency; off-cycle data is junk so a mistimed capture shows up
    always @(posedge clock) begin
        if (mem_read_enable) mem_read_data <= mem_rd(mem_addr);
        else                 mem_read_data <= 8'hEE;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // monitor: pops the scoreboard on every DUT event
    always @(negedge clock) begin
        if (!reset) begin
            if (mem_read_enable) begin
                reads_cnt++;
                if (rd_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_read: got addr 0x%0h expected no read", mem_addr);
                end else begin
                    chk("read_addr", mem_addr, rd_q.pop_front());
                end
                chk("read_while_valid", {31'd0, out_valid}, 32'd0);
            end
            if (stall_prev) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_hold", {21'd0, out_data, out_index, out_last},
                    {21'd0, s_data, s_idx, s_last});
            end
            if (done) begin
                chk("done_timing", {31'd0, (cur_len == 0) ? 1'b1 : prev_last_hs}, 32'd1);
            end
            prev_last_hs = 1'b0;
            if (out_valid && out_ready) begin
                hs_cnt++;
                prev_last_hs = out_last;
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_byte: got 0x%0h expected no byte", out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("byte", {21'd0, out_data, out_index, out_last},
                        {21'd0, e.data, e.idx, e.last});
                end
            end
            stall_prev = out_valid && !out_ready;
            s_data = out_data; s_idx = out_index; s_last = out_last;
        end
    end

    task automatic step();
        @(posedge clock); #1;
    endtask

    // stall: hold ready low for 5 cycles at first byte; inject: mid-transfer start
    task automatic run(input logic [31:0] base, input logic [15:0] len,
                       input bit stall, input bit inject);
        int eff;
        bit seen;
        eff = int'(len & 16'hFFFC);
        cur_len = eff; reads_cnt = 0; hs_cnt = 0;
        for (int k = 0; k < eff; k++) begin
            exp_t e;
            e.data = mem_rd(base + 32'(k));
            e.idx  = 2'(k);
            e.last = (k == eff - 1);
            exp_q.push_back(e);
            rd_q.push_back(base + 32'(k));
        end
        out_ready = !stall;
        base_addr = base; length = len; start = 1'b1;
        step();
        start = 1'b0; base_addr = 32'hDEAD_BEEF; length = 16'hFFFF;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        if (eff == 0) begin
            chk("zero_done", {31'd0, done}, 32'd1);
            chk("zero_nodata", {30'd0, out_valid, mem_read_enable}, 32'd0);
            step();
            chk("zero_idle", {30'd0, busy, done}, 32'd0);
        end else begin
            chk("first_read_lat", {30'd0, mem_read_enable, out_valid}, 32'd2);
            step();
            chk("wait_quiet", {30'd0, mem_read_enable, out_valid}, 32'd0);
            step();
            chk("first_valid_lat", {31'd0, out_valid}, 32'd1);
            if (stall) begin
                repeat (5) step();
                out_ready = 1'b1;
            end
            if (inject) begin
                step();
                base_addr = 32'h300; length = 16'd16; start = 1'b1;
                step();
                start = 1'b0;
            end
            seen = 0;
            for (int c = 0; c < 300 && !seen; c++) begin
                if (done) seen = 1;
                else step();
            end
            if (!seen) begin
                checks++; failures++;
                $display("FAIL done_timeout: got no done expected done within 300 cycles");
            end
            step();
            chk("idle_after_done", {30'd0, busy, done}, 32'd0);
        end
        @(negedge clock);
        chk("bytes_left", exp_q.size(), 0);
        chk("reads_left", rd_q.size(), 0);
        chk("read_count", reads_cnt, eff);
        exp_q.delete(); rd_q.delete();
        repeat (2) step();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
        mem[32'h0] = 8'h00; mem[32'h1] = 8'hC5; mem[32'h2] = 8'h87; mem[32'h3] = 8'hB3;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("reset_outputs", {mem_read_enable, out_valid, out_data, out_index, out_last, busy, done},
            32'd0);
        chk("reset_addr", mem_addr, 32'd0);

        run(32'h0, 16'd4, 0, 0);
        run(32'h100, 16'd10, 0, 0);
        run(32'h40, 16'd3, 0, 0);
        run(32'h40, 16'd0, 0, 0);
        run(32'h20, 16'd8, 1, 0);
        run(32'hFFFF_FFFE, 16'd4, 0, 0);

        // abandon an 8-byte transfer while byte 2 is on the bus
        cur_len = 8; hs_cnt = 0; reads_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            exp_t e;
            e.data = mem_rd(32'h200 + 32'(k)); e.idx = 2'(k); e.last = (k == 7);
            exp_q.push_back(e);
            rd_q.push_back(32'h200 + 32'(k));
        end
        base_addr = 32'h200; length = 16'd8; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 100 && !(hs_cnt == 2 && out_valid); c++) step();
        chk("reached_byte2", {31'd0, (hs_cnt == 2 && out_valid)}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_state", {29'd0, out_valid, busy, done}, 32'd0);
        step();
        chk("abort_nodone", {30'd0, done, busy}, 32'd0);
        exp_q.delete(); rd_q.delete();
        step();

        run(32'h0, 16'd4, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
